// File: rtl/phy_rx_pkg.sv
// Shared receive/transmit PHY definitions: default word geometry, comma
// payload, alignment FSM state encoding and phase counter width.
package phy_rx_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam logic [7:0]  COMMA_DEF = 8'hBC;

  // Four lanes are serialized per frame, so the phase counter is 2 bits.
  localparam int unsigned PHASE_W   = 2;

  localparam logic [0:0]  ST_SEARCH = 1'b0;
  localparam logic [0:0]  ST_LOCKED = 1'b1;

endpackage

// File: rtl/rx_align_fsm.sv
// Lane alignment FSM: hunts for the lane-0 comma, tracks the lane phase once
// locked, and counts misplaced commas to decide when lock has been lost.
module rx_align_fsm
  import phy_rx_pkg::*;
#(
  parameter int unsigned MISS_MAX = 2
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic               i_comma,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_locked,
  output logic               o_drop
);

  localparam int unsigned MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  logic [0:0]         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [MISS_W-1:0]  r_miss;
  logic [MISS_W:0]    w_miss_inc;
  logic               w_misplaced;

  // Misplaced-comma detection and the loss-of-lock decision for this edge.
  always_comb begin
    w_miss_inc  = {1'b0, r_miss} + (MISS_W + 1)'(1);
    w_misplaced = (r_state == ST_LOCKED) && i_comma && (r_phase != '0);
    o_drop      = w_misplaced && (w_miss_inc >= (MISS_W + 1)'(MISS_MAX));
  end

  // State, phase and miss counter update.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_state <= ST_SEARCH;
      r_phase <= '0;
      r_miss  <= '0;
    end else if (r_state == ST_SEARCH) begin
      if (i_comma) begin
        r_state <= ST_LOCKED;
        r_phase <= PHASE_W'(1);
        r_miss  <= '0;
      end
    end else begin
      if (o_drop) begin
        // The triggering comma is consumed here, not reused for alignment.
        r_state <= ST_SEARCH;
        r_phase <= '0;
        r_miss  <= '0;
      end else begin
        r_phase <= r_phase + PHASE_W'(1);
        if (i_comma && (r_phase == '0))
          r_miss <= '0;
        else if (w_misplaced)
          r_miss <= w_miss_inc[MISS_W-1:0];
      end
    end
  end

  assign o_phase  = r_phase;
  assign o_locked = (r_state == ST_LOCKED);

endmodule

// File: rtl/demux_l2_rx.sv
// Receive lane demultiplexer: rebuilds four parallel lanes from the
// serialized clk_4f word stream and strobes each completed frame.
module demux_l2_rx
  import phy_rx_pkg::*;
#(
  parameter int unsigned      WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(COMMA_DEF),
  parameter int unsigned      MISS_MAX = 2
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH:0]   in_data,
  output logic [WIDTH:0]   data0,
  output logic [WIDTH:0]   data1,
  output logic [WIDTH:0]   data2,
  output logic [WIDTH:0]   data3,
  output logic             frame_valid,
  output logic             locked
);

  logic               w_comma;
  logic [PHASE_W-1:0] w_phase;
  logic               w_locked;
  logic               w_drop;

  logic [WIDTH:0]     r_sh0, r_sh1, r_sh2;
  logic [WIDTH:0]     r_d0, r_d1, r_d2, r_d3;
  logic               r_fv;

  // Comma comparator: valid flag set and payload equal to the comma value.
  always_comb begin
    w_comma = (in_data == {1'b1, COMMA});
  end

  rx_align_fsm #(
    .MISS_MAX (MISS_MAX)
  ) u_fsm (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .i_comma  (w_comma),
    .o_phase  (w_phase),
    .o_locked (w_locked),
    .o_drop   (w_drop)
  );

  // Shadow capture of lanes 0..2 and simultaneous frame load on lane 3.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_d3  <= '0;
      r_fv  <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      if (!w_locked) begin
        if (w_comma)
          r_sh0 <= in_data;
      end else if (!w_drop) begin
        // Loss of lock takes priority over a phase-3 capture on the same edge.
        case (w_phase)
          2'd0: r_sh0 <= in_data;
          2'd1: r_sh1 <= in_data;
          2'd2: r_sh2 <= in_data;
          default: begin
            r_d0 <= r_sh0;
            r_d1 <= r_sh1;
            r_d2 <= r_sh2;
            r_d3 <= in_data;
            r_fv <= 1'b1;
          end
        endcase
      end
    end
  end

  assign data0       = r_d0;
  assign data1       = r_d1;
  assign data2       = r_d2;
  assign data3       = r_d3;
  assign frame_valid = r_fv;
  assign locked      = w_locked;

endmodule

// File: tb/tb_demux_l2_rx.sv
// Directed bench for demux_l2_rx: alignment, framing, valid=0 passthrough,
// loss of lock via misplaced commas, and mid-frame reset.
module tb_demux_l2_rx;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [8:0] in_data = '0;
  logic [8:0] data0, data1, data2, data3;
  logic       frame_valid, locked;

  int unsigned checks = 0;
  int unsigned errors = 0;

  demux_l2_rx #(
    .WIDTH    (8),
    .COMMA    (8'hBC),
    .MISS_MAX (2)
  ) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .in_data     (in_data),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .frame_valid (frame_valid),
    .locked      (locked)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word, let it be sampled, then settle past the edge.
  task automatic step(input logic [8:0] w);
    in_data = w;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [8:0] e0, input logic [8:0] e1,
                           input logic [8:0] e2, input logic [8:0] e3);
    chk({tag, "_fv"}, {8'h0, frame_valid}, 9'h001);
    chk({tag, "_d0"}, data0, e0);
    chk({tag, "_d1"}, data1, e1);
    chk({tag, "_d2"}, data2, e2);
    chk({tag, "_d3"}, data3, e3);
  endtask

  task automatic chk_quiet(input string tag, input logic exp_lock);
    chk({tag, "_fv"},  {8'h0, frame_valid}, 9'h000);
    chk({tag, "_lck"}, {8'h0, locked}, {8'h0, exp_lock});
  endtask

  initial begin
    logic [8:0] noise [8];
    noise = '{9'h0BC, 9'h1BD, 9'h03C, 9'h1FF, 9'h000, 9'h1BE, 9'h0BD, 9'h155};

    // Reset held three cycles while the input toggles (commas included).
    reset = 1'b1;
    step(9'h1BC); chk_quiet("rst0", 1'b0);
    step(9'h0FF); chk_quiet("rst1", 1'b0);
    step(9'h1BC); chk_quiet("rst2", 1'b0);
    chk("rst_d0", data0, 9'h000);
    chk("rst_d3", data3, 9'h000);
    reset = 1'b0;

    // Non-comma words in SEARCH never lock; 0x0BC lacks the valid flag.
    for (int i = 0; i < 8; i++) begin
      step(noise[i]);
      chk_quiet("srch", 1'b0);
      chk("srch_d0", data0, 9'h000);
    end

    // Alignment and first two frames.
    step(9'h1BC); chk_quiet("lock0", 1'b1);
    step(9'h111); chk_quiet("lock1", 1'b1);
    step(9'h122); chk_quiet("lock2", 1'b1);
    step(9'h133); chk_frame("f1", 9'h1BC, 9'h111, 9'h122, 9'h133);
    step(9'h1BC); chk_quiet("f2p0", 1'b1);
    step(9'h144); chk_quiet("f2p1", 1'b1);
    step(9'h155); chk_quiet("f2p2", 1'b1);
    step(9'h166); chk_frame("f2", 9'h1BC, 9'h144, 9'h155, 9'h166);

    // Valid=0 word stored in lane 2 unchanged.
    step(9'h1BC); chk_quiet("f3p0", 1'b1);
    step(9'h177);
    step(9'h0AA);
    step(9'h188); chk_frame("f3", 9'h1BC, 9'h177, 9'h0AA, 9'h188);

    // First misplaced comma at phase 2 passes as data.
    step(9'h101);
    step(9'h102);
    step(9'h1BC); chk_quiet("miss1", 1'b1);
    step(9'h103); chk_frame("f4", 9'h101, 9'h102, 9'h1BC, 9'h103);

    // Second misplaced comma at phase 2 drops lock on that edge.
    step(9'h104);
    step(9'h105);
    step(9'h1BC); chk_quiet("miss2", 1'b0);
    step(9'h106); chk_quiet("miss2n", 1'b0);
    chk("hold_d0", data0, 9'h101);
    chk("hold_d3", data3, 9'h103);

    // Re-lock on the next comma.
    step(9'h1BC); chk_quiet("relock", 1'b1);
    step(9'h1C1);
    step(9'h1C2);
    step(9'h1C3); chk_frame("f5", 9'h1BC, 9'h1C1, 9'h1C2, 9'h1C3);

    // Reset at phase 2 of a locked frame.
    step(9'h1BC);
    step(9'h1D1);
    reset = 1'b1;
    step(9'h1D2); chk_quiet("mrst", 1'b0);
    chk("mrst_d0", data0, 9'h000);
    chk("mrst_d2", data2, 9'h000);
    reset = 1'b0;
    step(9'h1D3); chk_quiet("mrst1", 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(9'h1D4 + 9'(i));
      chk_quiet("mrst_nolock", 1'b0);
    end
    step(9'h1BC); chk_quiet("relock2", 1'b1);
    step(9'h1E1);
    step(9'h1E2);
    step(9'h1E3); chk_frame("f6", 9'h1BC, 9'h1E1, 9'h1E2, 9'h1E3);
    step(9'h1BC); chk_quiet("f6_end", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_l2_rx.md
# demux_l2_rx

Receive-side lane demultiplexer that consumes the serialized 9-bit word stream produced by `phy_tx` (`outEtapaL2`) and rebuilds the four parallel lanes `data0`..`data3`. It runs entirely in the `clk_4f` domain. It aligns to a comma word marking lane 0, then emits one four-lane frame every four cycles with a one-cycle strobe. It is the first stage of the receive path, directly downstream of the transmit mux.

## Interface
- `WIDTH`, 8: payload bits per word. A word is `WIDTH+1` bits, with bit `WIDTH` as the valid flag.
- `COMMA`, 8'hBC: payload value that marks lane 0 when its valid bit is set.
- `MISS_MAX`, 2: number of consecutive misplaced commas that forces loss of lock.
- `clk_4f`  in  1: sole clock. Everything samples on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH+1: serialized stream from the transmit mux, one word per cycle, in lane order 0,1,2,3.
- `data0`..`data3`  out  WIDTH+1 each: reconstructed lanes, registered.
- `frame_valid`  out  1: one-cycle strobe. It is high in the cycle where `data0`..`data3` hold a newly completed frame.
- `locked`  out  1: high while the FSM is in LOCKED.

## Operation
- Comma word: `in_data == {1'b1, COMMA}`.
- FSM has two states:
  - SEARCH (reset state).
  - LOCKED.
- Internal registers:
  - 2-bit `phase` counter.
  - `miss_cnt` counter, width of `MISS_MAX` (saturates).
  - Shadow registers `sh0`..`sh2` for lanes 0..2.
- SEARCH:
  - Non-comma words are ignored.
  - On a comma: `sh0 <= in_data`, `phase <= 1`, `miss_cnt <= 0`, go to LOCKED.
- LOCKED:
  - Every cycle `phase` increments, wrapping 3→0.
  - phase 0, 1, 2: write `in_data` into `sh0`, `sh1`, `sh2` respectively.
  - phase 3: load `data0<=sh0`, `data1<=sh1`, `data2<=sh2`, `data3<=in_data` simultaneously, and set `frame_valid<=1`.
- Words with valid=0 are stored in their lane position unchanged. No filtering is done.
- Comma checks in LOCKED:
  - Comma at phase 0 clears `miss_cnt`.
  - Comma at phase 1..3 increments `miss_cnt`.
  - If the increment reaches `MISS_MAX`, on that edge: go to SEARCH, set `phase <= 0` and `miss_cnt <= 0`. The in-progress partial frame is discarded, with no `frame_valid`. The triggering comma is not reused for alignment.
  - Misplaced commas below `MISS_MAX` are stored as ordinary data.
- In SEARCH, outputs `data0`..`data3` hold their last values and `frame_valid` stays 0.

## Timing
- Reset (synchronous, takes effect at the first rising edge with `reset=1`):
  - `data0`..`data3` = 0, `frame_valid` = 0, `locked` = 0.
  - State SEARCH, `phase` = 0, `miss_cnt` = 0, shadows = 0.
- Reset mid-frame drops the partial frame. No strobe is emitted for it.
- `locked` is registered. It rises on the edge that samples the aligning comma.
- Latency:
  - A lane-3 word sampled at edge t appears on `data3` after edge t.
  - Lane-0 word sampled at t−3 appears on `data0` after that same edge t.
  - `frame_valid` is high for exactly the cycle t..t+1.
- Steady-state throughput: one frame per 4 cycles, so `frame_valid` has a 1-in-4 duty.
- First frame after lock: the comma is frame word 0, and `frame_valid` fires 3 cycles after the comma is sampled.
- Loss of lock and a phase-3 capture on the same edge: loss of lock wins. No strobe, and outputs are not updated.

## Structure
- Shared package `phy_rx_pkg`:
  - Default `COMMA` and `WIDTH`.
  - State encoding (SEARCH=1'b0, LOCKED=1'b1).
  - Phase width localparam.
  - The transmit side uses the same package for its comma constant.
- One sub-module, `rx_align_fsm`:
  - Contains the FSM, the `phase` counter and `miss_cnt`.
  - Outputs `phase`, `locked` and a `drop` pulse.
- Top level holds the shadow and output registers and the comma comparator.

## Test plan
- Reset held 3 cycles while `in_data` toggles → all outputs 0, `locked=0`, no strobe.
- Stream of 8 random non-comma words in SEARCH → `locked` stays 0, outputs unchanged.
- Sequence 0x1BC, 0x111, 0x122, 0x133, then repeating 0x1BC/0x144/0x155/0x166:
  - `locked` rises after the first comma.
  - First strobe shows data0..3 = 0x1BC, 0x111, 0x122, 0x133.
  - Next strobe, 4 cycles later, shows 0x1BC, 0x144, 0x155, 0x166.
- Locked stream with one word at valid=0 (0x0AA in lane 2) → `data2=0x0AA` on the strobe, and the frame is otherwise normal.
- Two consecutive frames each with the comma injected at phase 2 (`MISS_MAX=2`):
  - First misplaced comma passes as data.
  - Second one drops `locked` on that edge, no strobe for that frame.
  - Re-lock occurs on the next comma.
- Assert `reset` at phase 2 of a locked frame → no strobe, outputs zeroed, and re-alignment is required before the next `frame_valid`.
